// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART TX arbiter slice.
//   state_e          : arbiter FSM states (IDLE, SEND)
//   *_DEF            : default values for N_REQ, DATA_W and TIMEOUT_CYCLES
//   grant_w()        : width of a requester index (clog2(N_REQ), at least 1)
//   tmo_cnt_w()      : width of the idle-mid-packet timeout counter
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int N_REQ_DEF          = 2;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  // A one-bit index is still needed when N_REQ is 2 (clog2 would also give 1,
  // but the guard keeps the function safe for degenerate values).
  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  function automatic int tmo_cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set bit of `valid` at or
// above `ptr`, wrapping from N_REQ-1 back to 0.
// Ports:
//   valid [N_REQ]   : request vector
//   ptr   [GRANT_W] : highest-priority index for this pick
//   idx   [GRANT_W] : chosen index (0 when nothing is valid)
//   any             : at least one request is valid
// -----------------------------------------------------------------------------
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int  N_REQ   = N_REQ_DEF,
  localparam int GRANT_W = grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0]   valid,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] idx,
  output logic               any
);

  logic [GRANT_W-1:0] cand;

  // Scan from farthest to nearest offset so the nearest valid one wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = GRANT_W'((int'(ptr) + k) % N_REQ);
      if (valid[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the single UART TX FIFO write port among N_REQ byte-stream
// requesters, round-robin at packet granularity: the owner keeps the port
// until it delivers a byte flagged `last`.
// Optional feature: define UART_ARB_TIMEOUT_EN to release an owner that stays
// silent mid-packet for TIMEOUT_CYCLES cycles.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   req_valid/last     : per-requester byte present / end of packet
//   req_data           : byte of requester i in [i*DATA_W +: DATA_W]
//   req_ready          : per-requester accept strobe
//   tx_full            : UART TX FIFO full
//   wr_uart, w_data    : one-cycle write pulse and byte to the FIFO
//   grant              : index of the current owner
//   busy               : high while a packet is being forwarded (SEND)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int  N_REQ          = N_REQ_DEF,
  parameter int  DATA_W         = DATA_W_DEF,
  parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int GRANT_W        = grant_w(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_full,
  output logic                      wr_uart,
  output logic [DATA_W-1:0]         w_data,
  output logic [GRANT_W-1:0]        grant,
  output logic                      busy
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_e             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] pick_idx, grant_inc;
  logic               pick_any;
  logic               accept;
  logic               timeout_hit;
  logic               wr_uart_q;
  logic [DATA_W-1:0]  w_data_q;
  logic [DATA_W-1:0]  data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign grant_inc = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Output process. Ready is withheld in the cycle a write is in flight so
  // tx_full always reflects that write before the next accept.
  always_comb begin
    req_ready = '0;
    if (state_q == SEND) begin
      req_ready[grant_q] = ~tx_full & ~wr_uart_q;
    end
  end

  assign accept = req_valid[grant_q] & req_ready[grant_q];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts silent cycles of the owner; hit fires on the TIMEOUT_CYCLES-th one.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    timeout_hit = 1'b0;
    if (state_q != SEND || accept) begin
      tmo_cnt_d = '0;
    end else if (!req_valid[grant_q]) begin
      if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
        tmo_cnt_d   = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) tmo_cnt_q <= '0;
    else      tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state process.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if ((accept && req_last[grant_q]) || timeout_hit) begin
          state_d  = IDLE;
          rr_ptr_d = grant_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Write port registers; reset wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_uart_q <= 1'b0;
      w_data_q  <= '0;
    end else begin
      wr_uart_q <= accept;
      if (accept) w_data_q <= data_arr[grant_q];
    end
  end

  assign wr_uart = wr_uart_q;
  assign w_data  = w_data_q;
  assign grant   = grant_q;
  assign busy    = (state_q == SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with two requesters. A requester driver
// replays per-requester byte queues (holding each byte until accepted), a
// monitor logs every FIFO write, and the main sequence checks cycle-level
// behaviour against hand-computed values. The silent-owner test depends on
// UART_ARB_TIMEOUT_EN (timeout variant when defined, hold variant otherwise).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 8;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        tx_full = 1'b0;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic [0:0]  grant;
  logic        busy;

  uart_tx_arbiter #(
    .N_REQ          (N_REQ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  byte_t      q0[$];
  byte_t      q1[$];
  logic [7:0] wq[$];
  int         wcyc[$];
  logic [1:0] mute = '0;
  logic [1:0] acc  = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Requester driver: pops a byte one negedge after it was seen accepted,
  // presents the queue head at negedge, samples the handshake at negedge+2.
  initial begin
    forever begin
      @(negedge clk);
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      req_valid[0]   = (q0.size() > 0) && !mute[0];
      req_data[7:0]  = (q0.size() > 0) ? q0[0].d : 8'h00;
      req_last[0]    = (q0.size() > 0) ? q0[0].l : 1'b0;
      req_valid[1]   = (q1.size() > 0) && !mute[1];
      req_data[15:8] = (q1.size() > 0) ? q1[0].d : 8'h00;
      req_last[1]    = (q1.size() > 0) ? q1[0].l : 1'b0;
      #2;
      acc = req_valid & req_ready & {2{rst}};
    end
  end

  // Write monitor.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (wr_uart) begin
        wq.push_back(w_data);
        wcyc.push_back(cyc);
        $display("[%0d] write 0x%02h (grant %0d)", cyc, w_data, grant);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    if (r == 0) q0.push_back({d, l});
    else        q1.push_back({d, l});
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (wq.size() < n && b < budget) begin
      step();
      b++;
    end
    check(tag, wq.size(), n);
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int b;
    b = 0;
    while (!wr_uart && b < budget) begin
      step();
      b++;
    end
    check(tag, {31'd0, wr_uart}, 1);
  endtask

  function automatic logic [31:0] wq_at(input int i);
    return (i < wq.size()) ? {24'd0, wq[i]} : 32'hDEAD;
  endfunction

  logic [7:0] t1_exp [3];
  logic [7:0] t2_exp [6];
  int         b;

  initial begin
    t1_exp = '{8'h41, 8'h42, 8'h0A};
    t2_exp = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13};

    // Reset values.
    rst = 1'b0;
    repeat (3) step();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", wr_uart, 0);
    check("rst_wdata", w_data, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b1;
    step();

    // T1: three-byte packet from req0, writes at cycles 2,4,6.
    wq.delete();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h0A, 1'b1);
    step();
    check("t1_c0_busy", busy, 0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t1_c%0d_wr", k), wr_uart, (k == 2 || k == 4 || k == 6));
      check($sformatf("t1_c%0d_busy", k), busy, (k <= 5));
      if (k == 2 || k == 4 || k == 6)
        check($sformatf("t1_c%0d_data", k), w_data, t1_exp[k/2 - 1]);
      if (k == 1)
        check("t1_c1_ready", req_ready, 2'b01);
    end

    // T2: both valid at reset release; req0 has a second packet queued.
    rst = 1'b0;
    push(0, 8'h10, 1'b0);
    push(0, 8'h11, 1'b1);
    push(0, 8'h12, 1'b0);
    push(0, 8'h13, 1'b1);
    push(1, 8'h20, 1'b0);
    push(1, 8'h21, 1'b1);
    step();
    step();
    wq.delete();
    wcyc.delete();
    rst = 1'b1;
    wait_writes("t2_count", 6, 100);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_order%0d", i), wq_at(i), t2_exp[i]);
    if (wcyc.size() >= 2)
      check("t2_b2b_gap", wcyc[1] - wcyc[0], 2);

    // T3: tx_full for 10 cycles mid-packet; rr_ptr is now 1, req0 still wins.
    step();
    wq.delete();
    push(0, 8'h51, 1'b0);
    push(0, 8'h52, 1'b0);
    push(0, 8'h53, 1'b1);
    wait_wr("t3_first", 20);
    tx_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t3_hold%0d", i), {req_ready, wr_uart}, 3'b000);
    end
    tx_full = 1'b0;
    step();
    check("t3_resume_wr", wr_uart, 1);
    check("t3_resume_data", w_data, 8'h52);
    wait_writes("t3_count", 3, 40);
    check("t3_byte0", wq_at(0), 8'h51);
    check("t3_byte2", wq_at(2), 8'h53);

`ifndef UART_ARB_TIMEOUT_EN
    // T4: req1 owns the port and goes silent; req0 must wait.
    step();
    wq.delete();
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b1);
    wait_wr("t4_first", 20);
    check("t4_grant", grant, 1);
    mute[1] = 1'b1;
    push(0, 8'h71, 1'b1);
    for (int i = 0; i < 50; i++) begin
      step();
      check($sformatf("t4_hold%0d", i), {grant, req_ready[0], wr_uart, busy}, 4'b1001);
    end
    mute[1] = 1'b0;
    wait_writes("t4_count", 3, 40);
    check("t4_byte1", wq_at(1), 8'h62);
    check("t4_byte2", wq_at(2), 8'h71);
`else
    // T5: owner req1 silent; released after 16 silent cycles, req0 granted.
    step();
    wq.delete();
    push(1, 8'h81, 1'b0);
    push(1, 8'h82, 1'b1);
    wait_wr("t5_first", 20);
    mute[1] = 1'b1;
    push(0, 8'h91, 1'b1);
    repeat (16) step();
    check("t5_still_send", {grant, busy, req_ready[0]}, 3'b110);
    step();
    check("t5_idle", {busy, wr_uart}, 2'b00);
    wait_writes("t5_count", 2, 20);
    check("t5_byte", wq_at(1), 8'h91);
    check("t5_grant", grant, 0);
    q1.delete();
    mute[1] = 1'b0;
`endif

    // T6: reset asserted in the cycle a byte is being accepted.
    repeat (3) step();
    wq.delete();
    push(1, 8'hA5, 1'b0);
    push(1, 8'hA6, 1'b1);
    b = 0;
    while (!req_ready[1] && b < 20) begin
      step();
      b++;
    end
    check("t6_ready", {req_valid[1], req_ready[1], grant}, 3'b111);
    rst = 1'b0;
    mute[1] = 1'b1;
    step();
    check("t6_wr", wr_uart, 0);
    check("t6_wdata", w_data, 0);
    check("t6_grant", grant, 0);
    check("t6_busy", busy, 0);
    check("t6_ready_rst", req_ready, 0);
    rst = 1'b1;
    q1.delete();
    mute[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_quiet%0d", i), {wr_uart, busy}, 2'b00);
    end
    check("t6_no_write", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port (`wr_uart`, `w_data`, `tx_full`) among up to eight byte-stream requesters, such as the echo path, a status/message generator and a debug dumper. It arbitrates round-robin at packet granularity: once a requester is granted, it keeps the port until it delivers a byte flagged `last`. The block sits between the requesters and the `uart` instance in `system`, and is the only driver of `wr_uart`/`w_data`.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..8.
- `DATA_W`, default 8: byte width; must match the UART `w_data` width.
- `TIMEOUT_CYCLES`, default 1024: idle-mid-packet limit. Used only when `UART_ARB_TIMEOUT_EN` is defined.
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: reset; synchronous, active-low.
- `req_valid`, in, N_REQ: bit i means requester i presents a byte.
- `req_data`, in, N_REQ*DATA_W: byte of requester i in slice [i*DATA_W +: DATA_W].
- `req_last`, in, N_REQ: bit i marks the presented byte as the end of a packet.
- `req_ready`, out, N_REQ: bit i is the accept strobe for requester i.
- `tx_full`, in, 1: UART TX FIFO full.
- `wr_uart`, out, 1: one-cycle write pulse to the UART TX FIFO.
- `w_data`, out, DATA_W: byte written when `wr_uart` is high.
- `grant`, out, GRANT_W: index of the current owner; GRANT_W = clog2(N_REQ).
- `busy`, out, 1: high while in SEND.

## Operation
- FSM states are IDLE and SEND.
- **IDLE**:
  - `req_ready` = 0.
  - If any `req_valid` is high, the `rr_pick` result is registered into `grant`, and the FSM goes to SEND.
  - `rr_pick` selects the first valid requester at or above `rr_ptr`, wrapping from N_REQ-1 to 0.
- **SEND**:
  - `req_ready[grant]` = ~`tx_full` & ~`wr_uart`. All other ready bits are 0.
  - Accept = `req_valid[grant]` & `req_ready[grant]`.
  - On accept, `w_data` <= byte and `wr_uart` <= 1 for exactly one cycle.
  - Accepting a byte with `req_last` = 1 sends the FSM to IDLE and sets `rr_ptr` <= (grant+1) mod N_REQ, with wrap.
- Writes are at most one per two cycles. This guarantees `tx_full` reflects any prior write before the next accept, so no write is ever issued into a full FIFO.
- Ownership is held for the whole packet. Other requesters wait regardless of their valid.
- If the owner drops `req_valid` mid-packet, the FSM stays in SEND and waits. The timeout feature is the exception.
- A requester may change `req_data` only after an accept. Bytes are never duplicated or reordered.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant` 0, `wr_uart` 0, `w_data` 0, `req_ready` 0, `busy` 0, timeout counter 0.
- Reset mid-packet aborts the packet. Any pending `wr_uart` pulse is dropped on the reset cycle.
- Latency, starting from valid first seen in IDLE at cycle 0:
  - SEND and `req_ready` at cycle 1 (if `tx_full` = 0).
  - `wr_uart` at cycle 2.
  - Back-to-back bytes take 2 cycles each.
- `tx_full` high in SEND keeps `req_ready` low with no accept. Accepts resume the cycle after it falls.
- A single-byte packet (`last` on the first byte) returns to IDLE the cycle after accept. Re-arbitration takes 1 IDLE cycle.
- If all requesters are valid, service order from reset is 0,1,…,N_REQ-1,0…

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter increments in SEND while `req_valid[grant]` = 0 and resets on every accept.
  - At TIMEOUT_CYCLES it forces IDLE and advances `rr_ptr` past `grant`. No byte is written.
- Not defined: no counter, and ownership is held indefinitely until `last`.

## Structure
- Package `uart_arb_pkg` holds:
  - The state enum (IDLE, SEND).
  - The defaults for N_REQ, DATA_W and TIMEOUT_CYCLES.
  - The GRANT_W function.
  - The timeout counter width, clog2(TIMEOUT_CYCLES+1).
- Sub-module `rr_pick` is a combinational round-robin picker: inputs `valid`[N_REQ] and `ptr`; outputs `idx` and `any`. The FSM, counters and output registers live in the top.

## Test plan
- Reset, then req0 sends 0x41,0x42,0x0A (last) with `tx_full` = 0 → `wr_uart` pulses at cycles 2,4,6 carrying 0x41,0x42,0x0A; `busy` falls after the last byte.
- req0 and req1 both valid at reset release with 2-byte packets → all of req0's bytes are written before any of req1's. The next simultaneous round serves req1 first.
- `tx_full` held high for 10 cycles mid-packet → `req_ready` stays 0 and no `wr_uart` pulses occur. Transfer resumes 1 cycle after `tx_full` falls with no byte lost.
- req1 granted, drops valid for 50 cycles mid-packet while req0 is valid → grant stays 1 and req0 gets no ready (macro undefined).
- With `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES = 16, the owner goes silent mid-packet → IDLE after 16 cycles, and the next valid requester is granted.
- `rst` low for 1 cycle right after an accept → no `wr_uart` pulse, all outputs at reset values, `grant` 0.
